// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS
// core. It owns the program counter and drives the instruction-memory address.
// It registers the fetched word and its PC+4 for decode. It also resolves
// control-flow redirects requested by the instruction currently in EX.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hazard-unit hold request; freezes PC and IF/ID
//   ex_pc_src_sel   PCSRC_* code of the EX instruction
//   ex_br_taken     branch condition from EX (used with PCSRC_BT only)
//   ex_pc_plus4     PC+4 of the EX instruction
//   ex_imm16        EX instruction [15:0]
//   ex_imm26        EX instruction [25:0]
//   ex_rs_val       forwarded rs value for JR/JALR
//   imem_addr       current PC (combinational from the PC register)
//   imem_rdata      instruction at imem_addr, same-cycle read
//   if_id_instr     registered instruction to decode
//   if_id_pc_plus4  registered PC+4 of if_id_instr
//   if_id_valid     1 = if_id_instr is a real fetched instruction
//   flush_id        1 in any cycle a redirect is taken
//   fetch_misalign  sticky flag: a redirect target had bits [1:0] != 0
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [2:0]  ex_pc_src_sel,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_pc_plus4,
  input  logic [15:0] ex_imm16,
  input  logic [25:0] ex_imm26,
  input  logic [31:0] ex_rs_val,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        flush_id,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {
    PCSRC_PLUS4 = 3'd0,
    PCSRC_BT    = 3'd1,
    PCSRC_JT    = 3'd2,
    PCSRC_JR    = 3'd3
  } pcsrc_e;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  assign pc_plus4  = pc + 32'd4;  // wraps modulo 2^32 with no flag
  assign imem_addr = pc;
  assign flush_id  = redirect;

  // Target selection; PLUS4 and undefined codes never redirect.
  always_comb begin
    target   = '0;
    redirect = 1'b0;
    case (ex_pc_src_sel)
      PCSRC_BT: begin
        target   = ex_pc_plus4 + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};
        redirect = ex_br_taken;
      end
      PCSRC_JT: begin
        target   = {ex_pc_plus4[31:28], ex_imm26, 2'b00};
        redirect = 1'b1;
      end
      PCSRC_JR: begin
        target   = ex_rs_val;
        redirect = 1'b1;
      end
      default: begin
        target   = '0;
        redirect = 1'b0;
      end
    endcase
  end

  // A redirect overrides stall: the wrong-path word in IF becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (redirect) begin
      pc             <= target;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      pc             <= pc_plus4;
      if_id_instr    <= imem_rdata;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misalign <= 1'b0;
    end else if (redirect && (target[1:0] != 2'b00)) begin
      fetch_misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
module tb_mips_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        taken = 1'b0;
  logic [31:0] ex_pp4 = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] rs = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        flush_id;
  logic        fetch_misalign;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  // instruction memory contents: word at address a is a ^ KEY
  assign imem_rdata = imem_addr ^ KEY;

  mips_fetch_stage #(.RESET_PC(32'h0000_3000), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_pc_src_sel(sel),
    .ex_br_taken(taken), .ex_pc_plus4(ex_pp4), .ex_imm16(imm16),
    .ex_imm26(imm26), .ex_rs_val(rs), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .flush_id(flush_id), .fetch_misalign(fetch_misalign)
  );

  function automatic bit ref_redirect();
    return (sel == 3'd2) || (sel == 3'd3) || (sel == 3'd1 && taken);
  endfunction

  function automatic logic [31:0] ref_target();
    int off;
    logic [31:0] t;
    off = $signed(imm16);
    t = '0;
    if (sel == 3'd1) t = ex_pp4 + 32'(off * 4);
    else if (sel == 3'd2) t = (ex_pp4 & 32'hF000_0000) | (32'(imm26) << 2);
    else if (sel == 3'd3) t = rs;
    return t;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = '0; m_pp4 = '0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic drive(input bit st, input logic [2:0] s, input bit tk,
                       input logic [31:0] p4, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] r);
    stall = st; sel = s; taken = tk; ex_pp4 = p4; imm16 = i16; imm26 = i26; rs = r;
  endtask

  task automatic idle();
    drive(0, 3'd0, 0, '0, '0, '0, '0);
  endtask

  // One rising edge; the model advances using the inputs held across it.
  task automatic tick();
    logic [31:0] t;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (ref_redirect()) begin
      t = ref_target();
      m_pc = t; m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
      if (t % 4 != 0) m_mis = 1'b1;
    end else if (!stall) begin
      m_instr = m_pc ^ KEY;
      m_pp4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (imem_addr !== 32'h0000_3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0000_3000); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
    total++; if (if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pp4 got=%h exp=0", if_id_pc_plus4); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", fetch_misalign); end
    total++; if (flush_id !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush_id); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (if_id_pc_plus4 !== 32'h3000 + 32'(4 * k)) begin bad++; $display("FAIL seq_pp4 got=%h exp=%h", if_id_pc_plus4, 32'h3000 + 32'(4 * k)); end
      total++; if (if_id_instr !== ((32'h3000 + 32'(4 * (k - 1))) ^ KEY)) begin bad++; $display("FAIL seq_instr got=%h exp=%h", if_id_instr, (32'h3000 + 32'(4 * (k - 1))) ^ KEY); end
      total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", if_id_valid); end
    end
  endtask

  task automatic test_stall();
    drive(1, 3'd0, 0, '0, '0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (imem_addr !== 32'h3008) begin bad++; $display("FAIL stall_pc got=%h exp=3008", imem_addr); end
      total++; if (if_id_instr !== (32'h3004 ^ KEY)) begin bad++; $display("FAIL stall_instr got=%h exp=%h", if_id_instr, 32'h3004 ^ KEY); end
      total++; if (if_id_pc_plus4 !== 32'h3008) begin bad++; $display("FAIL stall_pp4 got=%h exp=3008", if_id_pc_plus4); end
    end
    idle();
    tick();
    total++; if (if_id_instr !== (32'h3008 ^ KEY)) begin bad++; $display("FAIL unstall_instr got=%h exp=%h", if_id_instr, 32'h3008 ^ KEY); end
    total++; if (if_id_pc_plus4 !== 32'h300C) begin bad++; $display("FAIL unstall_pp4 got=%h exp=300c", if_id_pc_plus4); end
  endtask

  task automatic test_branch();
    drive(0, 3'd1, 1, 32'h3010, 16'hFFFC, '0, '0);
    #1;
    total++; if (flush_id !== 1'b1) begin bad++; $display("FAIL bt_flush got=%b exp=1", flush_id); end
    tick();
    idle();
    total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL bt_pc got=%h exp=3000", imem_addr); end
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin bad++; $display("FAIL bt_bubble got=%b/%h exp=0/0", if_id_valid, if_id_instr); end
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_instr !== (32'h3000 ^ KEY)) begin bad++; $display("FAIL bt_target got=%b/%h exp=1/%h", if_id_valid, if_id_instr, 32'h3000 ^ KEY); end
    drive(0, 3'd1, 0, 32'h3010, 16'hFFFC, '0, '0);
    #1;
    total++; if (flush_id !== 1'b0) begin bad++; $display("FAIL bt_nt_flush got=%b exp=0", flush_id); end
    tick();
    idle();
    total++; if (imem_addr !== 32'h3008) begin bad++; $display("FAIL bt_nt_pc got=%h exp=3008", imem_addr); end
  endtask

  task automatic test_jumps();
    drive(0, 3'd2, 0, 32'h3010, '0, 26'h0000C40, '0);
    tick();
    total++; if (imem_addr !== 32'h0000_3100) begin bad++; $display("FAIL jt_pc got=%h exp=00003100", imem_addr); end
    total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL jt_mis got=%b exp=0", fetch_misalign); end
    drive(0, 3'd3, 0, '0, '0, '0, 32'h0000_3203);
    tick();
    idle();
    total++; if (imem_addr !== 32'h0000_3203) begin bad++; $display("FAIL jr_pc got=%h exp=00003203", imem_addr); end
    total++; if (fetch_misalign !== 1'b1) begin bad++; $display("FAIL jr_mis got=%b exp=1", fetch_misalign); end
    repeat (3) tick();
    total++; if (fetch_misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b exp=1", fetch_misalign); end
    total++; if (imem_addr !== 32'h0000_320F) begin bad++; $display("FAIL jr_seq got=%h exp=0000320f", imem_addr); end
  endtask

  task automatic test_stall_redirect();
    drive(1, 3'd3, 0, '0, '0, '0, 32'h0000_4000);
    #1;
    total++; if (flush_id !== 1'b1) begin bad++; $display("FAIL sr_flush got=%b exp=1", flush_id); end
    tick();
    idle();
    total++; if (imem_addr !== 32'h0000_4000) begin bad++; $display("FAIL sr_pc got=%h exp=00004000", imem_addr); end
    total++; if (if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL sr_bubble got=%b/%h exp=0/0", if_id_valid, if_id_pc_plus4); end
  endtask

  task automatic test_wrap();
    drive(0, 3'd3, 0, '0, '0, '0, 32'hFFFF_FFFC);
    tick();
    idle();
    tick();
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", imem_addr); end
    total++; if (if_id_pc_plus4 !== 32'h0 || if_id_instr !== (32'hFFFF_FFFC ^ KEY)) begin bad++; $display("FAIL wrap_ifid got=%h/%h exp=0/%h", if_id_pc_plus4, if_id_instr, 32'hFFFF_FFFC ^ KEY); end
  endtask

  task automatic test_async_reset();
    repeat (2) tick();
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL async_pc got=%h exp=3000", imem_addr); end
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL async_ifid got=%b/%h/%h exp=0/0/0", if_id_valid, if_id_instr, if_id_pc_plus4); end
    total++; if (fetch_misalign !== 1'b0 || flush_id !== 1'b0) begin bad++; $display("FAIL async_flags got=%b/%b exp=0/0", fetch_misalign, flush_id); end
    model_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
    total++; if (if_id_instr !== (32'h3000 ^ KEY) || imem_addr !== 32'h3004) begin bad++; $display("FAIL rerelease got=%h/%h exp=%h/3004", if_id_instr, imem_addr, 32'h3000 ^ KEY); end
  endtask

  task automatic test_random();
    logic [2:0] s;
    logic [31:0] r;
    for (int i = 0; i < 300; i++) begin
      s = 3'($urandom_range(0, 7));
      r = (($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC));
      drive($urandom_range(0, 3) == 0, s, 1'($urandom), $urandom, 16'($urandom), 26'($urandom), r);
      if ($urandom_range(0, 2) != 0) sel = 3'd0;
      #1;
      total++; if (flush_id !== ref_redirect()) begin bad++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, flush_id, ref_redirect()); end
      tick();
      total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, imem_addr, m_pc); end
      total++; if (if_id_instr !== m_instr) begin bad++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, if_id_instr, m_instr); end
      total++; if (if_id_pc_plus4 !== m_pp4) begin bad++; $display("FAIL rnd_pp4 i=%0d got=%h exp=%h", i, if_id_pc_plus4, m_pp4); end
      total++; if (if_id_valid !== m_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, if_id_valid, m_valid); end
      total++; if (fetch_misalign !== m_mis) begin bad++; $display("FAIL rnd_mis i=%0d got=%b exp=%b", i, fetch_misalign, m_mis); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jumps();
    test_stall_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
